// File: rtl/rf_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file
// with one-cycle registered read latency.
//
// state  | meaning
// IDLE   | arbitrate; winning command is registered onto the RF port
// ISSUE  | RF access cycle (gnt/err visible); reads continue to RDWAIT
// RDWAIT | RF read data arriving; captured into rdata, rvalid next cycle
module rf_arbiter #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NREGS = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          err0,
  output logic          err1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] rf_port1,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_we,
  input  logic [DW-1:0] rf_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  localparam logic [31:0] NREGS_U = 32'(NREGS);

  state_t state;
  logic   last1;
  logic   cmd_id;
  logic   cmd_rd;
  logic   cmd_zero;

  logic          any_req;
  logic          win1;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_bad;
  logic          sel_zero;

  // With both requesting, the one not granted last wins.
  always_comb begin
    any_req   = req0 | req1;
    win1      = req1 & (~req0 | ~last1);
    sel_wr    = win1 ? wr1 : wr0;
    sel_addr  = win1 ? addr1 : addr0;
    sel_wdata = win1 ? wdata1 : wdata0;
    sel_bad   = 32'(sel_addr) >= NREGS_U;
    sel_zero  = (sel_addr == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last1    <= 1'b1;
      cmd_id   <= 1'b0;
      cmd_rd   <= 1'b0;
      cmd_zero <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata    <= '0;
      rf_port1 <= '0;
      rf_wdata <= '0;
      rf_we    <= 1'b0;
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rf_we    <= 1'b0;
      rf_port1 <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state    <= ISSUE;
            last1    <= win1;
            cmd_id   <= win1;
            gnt0     <= ~win1;
            gnt1     <= win1;
            err0     <= ~win1 & sel_bad;
            err1     <= win1 & sel_bad;
            cmd_rd   <= ~sel_wr & ~sel_bad;
            cmd_zero <= sel_zero;
            // Address 0 and illegal addresses never touch the file.
            if (!sel_bad && !sel_zero) begin
              rf_port1 <= sel_addr;
              rf_we    <= sel_wr;
              if (sel_wr) rf_wdata <= sel_wdata;
            end
          end
        end
        ISSUE: begin
          state <= cmd_rd ? RDWAIT : IDLE;
        end
        RDWAIT: begin
          rdata   <= cmd_zero ? '0 : rf_rdata;
          rvalid0 <= ~cmd_id;
          rvalid1 <= cmd_id;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 Parameter DW, 32, data width of register-file words.
REQ-002 Parameter AW, 5, address width of requester and register-file ports.
REQ-003 Parameter NREGS, 16, number of implemented registers; addresses >= NREGS are illegal.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-006 req0 / req1  input  1  access request from requester 0 / 1; held stable with wr, addr, wdata until gnt seen.
REQ-007 wr0 / wr1  input  1  1 = write, 0 = read.
REQ-008 addr0 / addr1  input  AW  target register.
REQ-009 wdata0 / wdata1  input  DW  write data.
REQ-010 gnt0 / gnt1  output  1  one-cycle pulse: request accepted.
REQ-011 err0 / err1  output  1  one-cycle pulse coincident with gnt: illegal address.
REQ-012 rvalid0 / rvalid1  output  1  one-cycle pulse: rdata valid for that requester.
REQ-013 rdata  output  DW  read data, valid only while an rvalid is high.
REQ-014 rf_port1  output  AW  register-file address port.
REQ-015 rf_wdata  output  DW  register-file write data.
REQ-016 rf_we  output  1  register-file write enable.
REQ-017 rf_rdata  input  DW  register-file read output, registered inside the file (one-cycle latency).

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, RDWAIT; arbitration occurs only in IDLE.
REQ-019 Arbitration SHALL be round-robin: single request wins; with both requests, the requester not granted last wins; last-grant pointer updates on every grant.
REQ-020 IDLE cycle T with a winner: registers command, gnt pulses in T+1, state -> ISSUE.
REQ-021 ISSUE (T+1), legal nonzero-address write: rf_port1=addr, rf_wdata=wdata, rf_we=1 for exactly this cycle; state -> IDLE.
REQ-022 ISSUE, legal nonzero-address read: rf_port1=addr, rf_we=0; state -> RDWAIT.
REQ-023 RDWAIT (T+2): rf_rdata captured into rdata at end of T+2; rvalid of the winner high in T+3; state -> IDLE, so new arbitration is possible in T+3.
REQ-024 Write to address 0: gnt given, no RF access (rf_we=0, rf_port1=0), returns to IDLE as a normal write.
REQ-025 Read of address 0: gnt given, no RF access, same timing as a normal read, rdata=0 with rvalid in T+3.
REQ-026 Address >= NREGS: gnt and err pulse together in T+1, no RF access, no rvalid; state -> IDLE.
REQ-027 Outside ISSUE: rf_port1=0, rf_we=0, rf_wdata holds last value.
REQ-028 Requests seen while not in IDLE SHALL be ignored (not queued); a request still held in the first IDLE cycle after its gnt is a new request.
REQ-029 At most one of gnt0/gnt1 and at most one of rvalid0/rvalid1 high in any cycle.
REQ-030 Throughput: write or error = 2 cycles per access; read = 3 cycles per access.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, all gnt/err/rvalid/rf_we = 0, rf_port1 = 0, rf_wdata = 0, rdata = 0, last-grant pointer = requester 1 (requester 0 wins first tie).
REQ-032 Reset mid-ISSUE or mid-RDWAIT SHALL abort the access with no rvalid; the requester reissues after reset.
REQ-033 First arbitration SHALL occur on the first rising edge with reset=1.

Verification
REQ-034 After reset, req0 write addr=3 wdata=0xDEADBEEF -> gnt0 in T+1, rf_we=1, rf_port1=3, rf_wdata=0xDEADBEEF in T+1 only.
REQ-035 Then req1 read addr=3, model returns 0xDEADBEEF -> gnt1 T+1, rf_port1=3 T+1, rvalid1 T+3 with rdata=0xDEADBEEF.
REQ-036 req0 and req1 held continuously (both writes) -> gnts alternate 0,1,0,1 every 2 cycles, starting with gnt0 after reset.
REQ-037 req0 read addr=0 -> gnt0, rf_port1 stays 0, rvalid0 in T+3 with rdata=0; req1 write addr=0 -> gnt1, rf_we never 1.
REQ-038 req1 read addr=20 -> gnt1 and err1 in T+1, no rf_we, no rvalid1, IDLE in T+2.
REQ-039 reset=0 asserted during RDWAIT of a read -> all outputs 0 immediately, no rvalid afterwards, next request after reset release granted normally.
